mp3_sci_reader: RTL
===================

Name: mp3_sci_reader

Overview:
- SCI register read master for the VS10xx MP3 decoder, covering the read direction of the MP3 serial interface.
- Issues a read command: opcode 0x03, then the register address. Then clocks in the 16-bit register value on MISO.
- Used to poll decoder status registers (e.g. DECODE_TIME, HDAT0) for game sound sequencing.
- Sits beside the existing MP3 write path; the top-level mux selects its CS/SCLK/MOSI when a read is in flight.

Parameters:
CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
RD_OPCODE, 8'h03, SCI read instruction byte
TIMEOUT_CYCLES, 1000000, max clk cycles waiting for DREQ (used only with MP3_SCI_TIMEOUT_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req  input  1  start a read; sampled only when busy=0
addr  input  4  SCI register address; latched on accept
busy  output  1  high from the cycle after accept until the done cycle inclusive
rdata  output  16  last register value read; updated only in the done cycle
done  output  1  one-cycle pulse when rdata is valid
err  output  1  one-cycle pulse on DREQ timeout (constant 0 without the macro)
DREQ  input  1  decoder ready
MISO  input  1  serial data from the decoder
CS  output  1  SCI chip select, active low
DCS  output  1  SDI chip select, held 1 at all times
SCLK  output  1  serial clock, idles 0
MOSI  output  1  serial data to the decoder, MSB first

Behaviour:
- Reset values: CS=1, DCS=1, SCLK=0, MOSI=0, busy=0, done=0, err=0, rdata=16'h0000. State returns to IDLE. Reset applies on the next clk edge, including mid-transfer, which aborts the transfer.
- States: IDLE -> WAIT_DREQ -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - req=1 latches the 32-bit shift word {RD_OPCODE, 4'h0, addr, 16'h0000}.
  - Next state is WAIT_DREQ; busy=1 from the next cycle.
- WAIT_DREQ:
  - Stays while DREQ=0.
  - On DREQ=1: enters SETUP next cycle, with CS=0 and MOSI=bit31.
- SETUP:
  - Lasts CLK_DIV cycles with SCLK=0, then enters SHIFT.
- SHIFT (32 bits):
  - Each bit is CLK_DIV cycles with SCLK=0, then CLK_DIV cycles with SCLK=1.
  - MOSI changes only while SCLK is low (on the falling-edge boundary).
  - MISO is sampled on the clk cycle in which SCLK goes 0->1 (SPI mode 0).
  - Bits 31..16: MOSI carries the command. MISO is ignored.
  - Bits 15..0: MOSI=0. MISO is shifted MSB-first into a capture register.
- HOLD:
  - After the 32nd falling edge, CS stays 0 for CLK_DIV cycles, then CS=1.
- DONE:
  - Lasts one cycle: done=1, rdata=capture, busy=1.
  - Next cycle: busy=0, state IDLE.
- Latency: done is asserted exactly 66*CLK_DIV cycles after the first CS=0 cycle.
- Back-to-back: req held high re-triggers in the cycle after DONE, giving a minimum gap of 1 idle cycle with CS=1.
- req while busy=1 is ignored and not queued. addr changes while busy have no effect.
- DREQ falling mid-transfer is ignored; DREQ is checked only in WAIT_DREQ.
- SCLK produces exactly 32 rising edges per transaction. No glitches on CS/SCLK/MOSI; all are driven from flops.

Optional Feature:
- MP3_SCI_TIMEOUT_EN defined:
  - WAIT_DREQ counts cycles.
  - If DREQ is still 0 after TIMEOUT_CYCLES cycles: err=1 for one cycle, busy drops to 0 in that same cycle, state returns to IDLE.
  - CS is never asserted on a timeout, and rdata is unchanged.
- MP3_SCI_TIMEOUT_EN undefined:
  - WAIT_DREQ waits indefinitely; err is tied 0 and no counter is built.

Test Plan:
- CLK_DIV=2, DREQ=1, req pulse with addr=4'h4; model drives MISO with 16'hA5C3 -> MOSI bits read 0x0304_0000, 32 SCLK rises, done one cycle with rdata=16'hA5C3, done 132 cycles after CS first low, CS=1 afterwards, DCS=1 throughout.
- DREQ=0 for 50 cycles after req, then 1 -> CS remains 1 and SCLK 0 throughout the wait; transfer starts the cycle after DREQ rises; result correct.
- req asserted again at cycle 20 of a transfer with addr=4'h9 -> ignored; MOSI still carries the first address; exactly one done pulse.
- rst=1 at SCLK rise 10 -> next edge CS=1, SCLK=0, busy=0, rdata=0; a new req then completes normally with rdata=16'h1234.
- req held high continuously, MISO words 16'h0001 then 16'hFFFF -> two done pulses, correct rdata each, CS high for at least 1 cycle between transfers.
- With MP3_SCI_TIMEOUT_EN defined, TIMEOUT_CYCLES=100, DREQ=0 -> err pulse 100 cycles into WAIT_DREQ, busy falls, CS never low, rdata unchanged.

Source files
------------

// File: rtl/mp3_sci_reader_if.sv
// Host and serial-side signals of the VS10xx SCI read master.
// The slave modport is the reader itself; the master modport is whatever drives it.
interface mp3_sci_reader_if;
    logic        req;
    logic [3:0]  addr;
    logic        busy;
    logic [15:0] rdata;
    logic        done;
    logic        err;
    logic        DREQ;
    logic        MISO;
    logic        CS;
    logic        DCS;
    logic        SCLK;
    logic        MOSI;

    modport master (
        output req, addr, DREQ, MISO,
        input  busy, rdata, done, err, CS, DCS, SCLK, MOSI
    );

    modport slave (
        input  req, addr, DREQ, MISO,
        output busy, rdata, done, err, CS, DCS, SCLK, MOSI
    );
endinterface

// File: rtl/mp3_sci_reader.sv
// SCI register read master for the VS10xx: sends {opcode, addr}, clocks in 16 bits (SPI mode 0).
// Optional DREQ timeout is enabled by defining MP3_SCI_TIMEOUT_EN.
module mp3_sci_reader #(
    parameter int         CLK_DIV        = 2,
    parameter logic [7:0] RD_OPCODE      = 8'h03,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input logic            clk,
    input logic            rst,
    mp3_sci_reader_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_DREQ, SETUP, SHIFT, HOLD, DONE} state_t;

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CMAX = CW'(CLK_DIV - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic          hi_q, hi_d;
    logic [31:0]   shift_q, shift_d;
    logic [15:0]   cap_q, cap_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [15:0]   rdata_q, rdata_d;

`ifdef MP3_SCI_TIMEOUT_EN
    localparam int            TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        hi_d    = hi_q;
        shift_d = shift_q;
        cap_d   = cap_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
`ifdef MP3_SCI_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    shift_d = {RD_OPCODE, 4'h0, bus.addr, 16'h0000};
                    busy_d  = 1'b1;
                    state_d = WAIT_DREQ;
`ifdef MP3_SCI_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            WAIT_DREQ: begin
                if (bus.DREQ) begin
                    state_d = SETUP;
                    cs_d    = 1'b0;
                    mosi_d  = shift_q[31];
                    cnt_d   = '0;
                end
`ifdef MP3_SCI_TIMEOUT_EN
                else if (tmo_q == TMO_MAX) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            SETUP: begin
                if (cnt_q == CMAX) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    hi_d    = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CMAX) begin
                    cnt_d = '0;
                    if (!hi_q) begin
                        // Rising SCLK: sample MISO; the last 16 samples are the register value.
                        hi_d   = 1'b1;
                        sclk_d = 1'b1;
                        cap_d  = {cap_q[14:0], bus.MISO};
                    end else begin
                        hi_d    = 1'b0;
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[30:0], 1'b0};
                        mosi_d  = shift_q[30];
                        if (bit_q == 5'd31) state_d = HOLD;
                        else                bit_d   = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (cnt_q == CMAX) begin
                    state_d = DONE;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    rdata_d = cap_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            hi_q    <= 1'b0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
`ifdef MP3_SCI_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            hi_q    <= hi_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef MP3_SCI_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        cap_q   <= cap_d;
    end

    assign bus.CS    = cs_q;
    assign bus.DCS   = 1'b1;
    assign bus.SCLK  = sclk_q;
    assign bus.MOSI  = mosi_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
`ifdef MP3_SCI_TIMEOUT_EN
    assign bus.err   = err_q;
`else
    // No timeout logic in this build: err evaluates to a constant 0.
    assign bus.err   = (TIMEOUT_CYCLES < 0);
`endif
endmodule
